// File: rtl/com_tx.sv
// -----------------------------------------------------------------------------
// com_tx -- packet framer between the communication controller and the PHY
//
// On a level start request (fs_tx) the framer latches the packet type, the
// first TX-RAM payload address and the payload length. It then streams a
// framed packet to the serializer:
//
//   8'h55, 8'hAA, {btype, rlen[11:8]}, rlen[7:0], payload[0..rlen-1], csum
//
// csum is the XOR of the TYPE byte, the LEN byte and every payload byte. The
// two header bytes are not part of the checksum. Once the checksum byte has
// been accepted, fd_tx is raised and held until the controller drops fs_tx.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   fs_tx        in   1   start request (level, held until fd_tx is seen)
//   fd_tx        out  1   packet done, high only in DONE
//   tx_btype     in   4   packet type, sampled at start
//   tx_ram_init  in  12   first payload RAM address, sampled at start
//   tx_ram_rlen  in  12   payload length in bytes, sampled at start
//   ram_rxa      out 12   TX RAM read address (registered)
//   ram_rxd      in   8   TX RAM read data, valid the cycle after ram_rxa
//   tx_data      out  8   outgoing byte
//   tx_valid     out  1   tx_data is valid
//   tx_ready     in   1   sink ready
//   dbg_state    out  4   current FSM state encoding, for observation only
//
// Handshake: a byte is transferred on every rising edge where
// tx_valid & tx_ready are both high. While tx_valid is high and tx_ready is
// low, tx_data and the FSM state are held unchanged, so each byte is
// delivered exactly once.
// -----------------------------------------------------------------------------
module com_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_tx,
    output logic        fd_tx,
    input  logic [3:0]  tx_btype,
    input  logic [11:0] tx_ram_init,
    input  logic [11:0] tx_ram_rlen,
    output logic [11:0] ram_rxa,
    input  logic [7:0]  ram_rxd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  dbg_state
);

    localparam logic [7:0] HDR0 = 8'h55;
    localparam logic [7:0] HDR1 = 8'hAA;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HEAD0 = 4'd1,
        S_HEAD1 = 4'd2,
        S_TYPE  = 4'd3,
        S_LEN   = 4'd4,
        S_RADDR = 4'd5,
        S_RWAIT = 4'd6,
        S_PAY   = 4'd7,
        S_CSUM  = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t      state;

    // Fields captured at start; frozen for the whole packet.
    logic [3:0]  pkt_btype;
    logic [11:0] pkt_init;
    logic [11:0] pkt_rlen;

    // Payload byte index (0..rlen) and running checksum.
    logic [11:0] idx;
    logic [7:0]  csum;

    logic        handshake;
    logic [7:0]  csum_next;
    logic [11:0] idx_next;

    assign handshake = tx_valid & tx_ready;
    // tx_data always holds the byte currently on offer, so folding it in on
    // the handshake edge gives the checksum including that byte.
    assign csum_next = csum ^ tx_data;
    assign idx_next  = idx + 12'd1;
    assign dbg_state = state;

    // All outputs are registered: each transition loads the values the next
    // state presents, so the byte appears in the same cycle the state is
    // entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fd_tx     <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            ram_rxa   <= 12'h000;
            pkt_btype <= 4'h0;
            pkt_init  <= 12'h000;
            pkt_rlen  <= 12'h000;
            idx       <= 12'h000;
            csum      <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fs_tx) begin
                        pkt_btype <= tx_btype;
                        pkt_init  <= tx_ram_init;
                        pkt_rlen  <= tx_ram_rlen;
                        idx       <= 12'h000;
                        csum      <= 8'h00;
                        tx_data   <= HDR0;
                        tx_valid  <= 1'b1;
                        state     <= S_HEAD0;
                    end
                end

                S_HEAD0: begin
                    if (handshake) begin
                        tx_data <= HDR1;
                        state   <= S_HEAD1;
                    end
                end

                S_HEAD1: begin
                    if (handshake) begin
                        tx_data <= {pkt_btype, pkt_rlen[11:8]};
                        state   <= S_TYPE;
                    end
                end

                S_TYPE: begin
                    if (handshake) begin
                        csum    <= csum_next;
                        tx_data <= pkt_rlen[7:0];
                        state   <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (handshake) begin
                        csum <= csum_next;
                        if (pkt_rlen != 12'h000) begin
                            // First payload address goes out with RADDR.
                            tx_valid <= 1'b0;
                            ram_rxa  <= pkt_init;
                            state    <= S_RADDR;
                        end else begin
                            // Empty payload: checksum is TYPE ^ LEN.
                            tx_data <= csum_next;
                            state   <= S_CSUM;
                        end
                    end
                end

                // Address is on the RAM bus during this cycle; data returns
                // in RWAIT.
                S_RADDR: begin
                    state <= S_RWAIT;
                end

                S_RWAIT: begin
                    tx_data  <= ram_rxd;
                    tx_valid <= 1'b1;
                    state    <= S_PAY;
                end

                S_PAY: begin
                    if (handshake) begin
                        csum <= csum_next;
                        idx  <= idx_next;
                        if (idx_next == pkt_rlen) begin
                            tx_data <= csum_next;
                            state   <= S_CSUM;
                        end else begin
                            // 12-bit add wraps FFF -> 000 naturally.
                            tx_valid <= 1'b0;
                            ram_rxa  <= pkt_init + idx_next;
                            state    <= S_RADDR;
                        end
                    end
                end

                S_CSUM: begin
                    if (handshake) begin
                        tx_valid <= 1'b0;
                        fd_tx    <= 1'b1;
                        state    <= S_DONE;
                    end
                end

                // Leaves only once the controller has dropped the request,
                // so a retransmit always needs a fresh fs_tx.
                S_DONE: begin
                    if (!fs_tx) begin
                        fd_tx <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    fd_tx    <= 1'b0;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                    ram_rxa  <= 12'h000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_tx.sv
module tb_com_tx;

    logic        clk;
    logic        rst;
    logic        fs_tx;
    logic        fd_tx;
    logic [3:0]  tx_btype;
    logic [11:0] tx_ram_init;
    logic [11:0] tx_ram_rlen;
    logic [11:0] ram_rxa;
    logic [7:0]  ram_rxd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  dbg_state;

    com_tx dut (
        .clk         (clk),
        .rst         (rst),
        .fs_tx       (fs_tx),
        .fd_tx       (fd_tx),
        .tx_btype    (tx_btype),
        .tx_ram_init (tx_ram_init),
        .tx_ram_rlen (tx_ram_rlen),
        .ram_rxa     (ram_rxa),
        .ram_rxd     (ram_rxd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- TX RAM model (1-cycle read) ----------------
    logic [7:0] ram [0:4095];
    always @(posedge clk) ram_rxd <= ram[ram_rxa];

    // ---------------- scoreboard state ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [11:0] exp_a[$];
    logic [11:0] got_a[$];
    int         stall_viol = 0;

    // ---------------- monitor ----------------
    bit         prev_stall = 0;
    bit         prev_valid = 0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_valid = 0;
        end else begin
            if (prev_stall && !(tx_valid === 1'b1 && tx_data === prev_data))
                stall_viol++;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            // A read address is presented on each valid 1->0 fall that is not
            // the end of the packet.
            if (!tx_valid && prev_valid && !fd_tx) got_a.push_back(ram_rxa);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_valid = tx_valid;
        end
    end

    // ---------------- reference model ----------------
    function automatic void build_expected(input logic [3:0] bt, input logic [11:0] init,
                                           input logic [11:0] rlen);
        logic [7:0] c;
        logic [7:0] t;
        int         ai;
        exp_q.delete();
        exp_a.delete();
        c = 8'h00;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        t = {bt, rlen[11:8]};
        exp_q.push_back(t);
        c = c ^ t;
        exp_q.push_back(rlen[7:0]);
        c = c ^ rlen[7:0];
        for (int i = 0; i < int'(rlen); i++) begin
            ai = (int'(init) + i) % 4096;
            exp_a.push_back(12'(ai));
            exp_q.push_back(ram[ai]);
            c = c ^ ram[ai];
        end
        exp_q.push_back(c);
    endfunction

    // ---------------- driver ----------------
    // mode 0: ready always high, 1: alternating, 2: random.
    task automatic run_packet(input logic [3:0] bt, input logic [11:0] init, input logic [11:0] rlen,
                              input int mode, input int hold,
                              output int start_lat, output int done_lat, output bit timeout,
                              output int fd_drop, output logic fd_after);
        int cyc;
        int first;
        int budget;
        bit alt;
        build_expected(bt, init, rlen);
        got_q.delete();
        got_a.delete();
        stall_viol = 0;
        start_lat = -1;
        done_lat  = -1;
        timeout   = 0;
        fd_drop   = 0;
        fd_after  = 1'bx;
        first     = -1;
        cyc       = 0;
        alt       = 0;
        budget    = 200 + 20 * (int'(rlen) + 5);
        @(posedge clk); #1;
        tx_btype    = bt;
        tx_ram_init = init;
        tx_ram_rlen = rlen;
        fs_tx       = 1'b1;
        tx_ready    = 1'b1;
        forever begin
            @(posedge clk); #1;
            // Inputs other than fs_tx are don't-care once the packet started.
            tx_btype    = 4'($urandom);
            tx_ram_init = 12'($urandom);
            tx_ram_rlen = 12'($urandom);
            case (mode)
                0:       tx_ready = 1'b1;
                1:       begin alt = ~alt; tx_ready = alt; end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cyc++;
            if (first < 0 && tx_valid) first = cyc;
            if (fd_tx) break;
            if (cyc > budget) begin
                timeout = 1;
                break;
            end
        end
        tx_ready = 1'b1;
        if (!timeout) begin
            start_lat = first;
            done_lat  = cyc - first;
        end
        repeat (hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!fd_tx) fd_drop++;
        end
        @(posedge clk); #1;
        fs_tx = 1'b0;
        @(posedge clk);
        @(negedge clk);
        fd_after = fd_tx;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        rst   = 1'b1;
        fs_tx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (fd_tx !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b expected 0", fd_tx); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", tx_data); end
        n_cmp++; if (ram_rxa !== 12'h000) begin n_err++; $display("FAIL reset_addr: got %h expected 000", ram_rxa); end
        @(posedge clk); #1;
        rst   = 1'b0;
        fs_tx = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_wins: tx_valid got %b expected 0", tx_valid); end
    endtask

    task automatic test_ack();
        int sl, dl, fdrop;
        bit to;
        logic fa;
        run_packet(4'h1, 12'($urandom), 12'h000, 0, 0, sl, dl, to, fdrop, fa);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL ack_timeout: fd_tx never rose"); end
        n_cmp++; if (sl !== 1) begin n_err++; $display("FAIL ack_start_lat: got %0d expected 1", sl); end
        n_cmp++; if (dl !== 5) begin n_err++; $display("FAIL ack_done_lat: got %0d expected 5", dl); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ack_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ack_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (fa !== 1'b0) begin n_err++; $display("FAIL ack_fd_fall: got %b expected 0", fa); end
    endtask

    task automatic test_data();
        int sl, dl, fdrop;
        bit to;
        logic fa;
        ram[12'h010] = 8'h01;
        ram[12'h011] = 8'h02;
        ram[12'h012] = 8'h04;
        run_packet(4'hD, 12'h010, 12'd3, 0, 0, sl, dl, to, fdrop, fa);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL data_timeout: fd_tx never rose"); end
        n_cmp++; if (dl !== 14) begin n_err++; $display("FAIL data_done_lat: got %0d expected 14", dl); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL data_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL data_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (got_a.size() !== exp_a.size()) begin n_err++; $display("FAIL data_addr_cnt: got %0d expected %0d", got_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < got_a.size()) begin
            n_cmp++; if (got_a[i] !== exp_a[i]) begin n_err++; $display("FAIL data_addr[%0d]: got %h expected %h", i, got_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_wrap();
        int sl, dl, fdrop;
        bit to;
        logic fa;
        run_packet(4'($urandom), 12'hFFE, 12'd3, 0, 0, sl, dl, to, fdrop, fa);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL wrap_timeout: fd_tx never rose"); end
        n_cmp++; if (got_a.size() !== exp_a.size()) begin n_err++; $display("FAIL wrap_addr_cnt: got %0d expected %0d", got_a.size(), exp_a.size()); end
        foreach (exp_a[i]) if (i < got_a.size()) begin
            n_cmp++; if (got_a[i] !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, got_a[i], exp_a[i]); end
        end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wrap_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int sl, dl, fdrop;
        bit to;
        logic fa;
        for (int m = 1; m <= 2; m++) begin
            if (m == 1) run_packet(4'hD, 12'h010, 12'd3, m, 0, sl, dl, to, fdrop, fa);
            else        run_packet(4'($urandom), 12'($urandom), 12'($urandom_range(1, 16)), m, 0, sl, dl, to, fdrop, fa);
            n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bp%0d_timeout: fd_tx never rose", m); end
            n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL bp%0d_stall: got %0d unstable stalls expected 0", m, stall_viol); end
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp%0d_len: got %0d expected %0d", m, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp%0d_byte[%0d]: got %h expected %h", m, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int vcnt, cyc, bad;
        bit hit;
        int sl, dl, fdrop;
        bit to;
        logic fa;
        @(posedge clk); #1;
        tx_btype    = 4'hD;
        tx_ram_init = 12'h010;
        tx_ram_rlen = 12'd3;
        tx_ready    = 1'b1;
        fs_tx       = 1'b1;
        vcnt = 0;
        cyc  = 0;
        hit  = 0;
        // Sixth valid cycle is the second payload byte on offer.
        while (!hit && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (tx_valid) vcnt++;
            if (vcnt == 6) hit = 1;
        end
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rmid_reach: second payload byte not reached"); end
        rst   = 1'b1;
        fs_tx = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (fd_tx !== 1'b0) begin n_err++; $display("FAIL rmid_fd: got %b expected 0", fd_tx); end
        n_cmp++; if (ram_rxa !== 12'h000) begin n_err++; $display("FAIL rmid_addr: got %h expected 000", ram_rxa); end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || fd_tx !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", bad); end
        run_packet(4'($urandom), 12'($urandom), 12'($urandom_range(1, 8)), 0, 0, sl, dl, to, fdrop, fa);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rmid_new_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_new_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_retransmit();
        int sl, dl, fdrop;
        bit to;
        logic fa;
        logic [3:0]  bt;
        logic [11:0] init, rlen;
        logic [7:0]  first_q[$];
        bt   = 4'($urandom);
        init = 12'($urandom);
        rlen = 12'($urandom_range(1, 6));
        for (int p = 0; p < 2; p++) begin
            run_packet(bt, init, rlen, 0, 4, sl, dl, to, fdrop, fa);
            n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rtx%0d_timeout: fd_tx never rose", p); end
            n_cmp++; if (fdrop !== 0) begin n_err++; $display("FAIL rtx%0d_fd_hold: got %0d low cycles expected 0", p, fdrop); end
            n_cmp++; if (fa !== 1'b0) begin n_err++; $display("FAIL rtx%0d_fd_fall: got %b expected 0", p, fa); end
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rtx%0d_len: got %0d expected %0d", p, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rtx%0d_byte[%0d]: got %h expected %h", p, i, got_q[i], exp_q[i]); end
            end
            if (p == 0) first_q = got_q;
            @(posedge clk);
        end
        n_cmp++; if (first_q.size() !== got_q.size()) begin n_err++; $display("FAIL rtx_same_len: got %0d expected %0d", got_q.size(), first_q.size()); end
    endtask

    task automatic test_random();
        int sl, dl, fdrop, mode;
        bit to;
        logic fa;
        logic [11:0] rlen;
        for (int n = 0; n < 6; n++) begin
            mode = (n % 2 == 0) ? 0 : 2;
            rlen = 12'($urandom_range(0, 12));
            run_packet(4'($urandom), 12'($urandom), rlen, mode, $urandom_range(0, 3), sl, dl, to, fdrop, fa);
            n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout: fd_tx never rose", n); end
            if (mode == 0) begin
                n_cmp++; if (dl !== 5 + 3 * int'(rlen)) begin n_err++; $display("FAIL rnd%0d_done_lat: got %0d expected %0d", n, dl, 5 + 3 * int'(rlen)); end
            end
            n_cmp++; if (fa !== 1'b0) begin n_err++; $display("FAIL rnd%0d_fd_fall: got %b expected 0", n, fa); end
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd%0d_len: got %0d expected %0d", n, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_byte[%0d]: got %h expected %h", n, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (got_a.size() !== exp_a.size()) begin n_err++; $display("FAIL rnd%0d_addr_cnt: got %0d expected %0d", n, got_a.size(), exp_a.size()); end
            foreach (exp_a[i]) if (i < got_a.size()) begin
                n_cmp++; if (got_a[i] !== exp_a[i]) begin n_err++; $display("FAIL rnd%0d_addr[%0d]: got %h expected %h", n, i, got_a[i], exp_a[i]); end
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst         = 1'b1;
        fs_tx       = 1'b0;
        tx_ready    = 1'b0;
        tx_btype    = 4'h0;
        tx_ram_init = 12'h000;
        tx_ram_rlen = 12'h000;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_ack();
        test_data();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_retransmit();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
